matvec3_driver: RTL and testbench
=================================

MATVEC3_DRIVER -- requirements
Module: matvec3_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14, giving the operand word width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 28, giving the result word width.
REQ-003 The block SHALL have parameter N, default 3, giving the matrix dimension; N*N+N operand words and N result words SHALL follow from it.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-006 ld_valid  input  1  operand buffer write strobe.
REQ-007 ld_addr  input  4  operand index: 0..8 = W row-major, 9..11 = x.
REQ-008 ld_data  input  WIDTH  signed operand word.
REQ-009 start  input  1  single-cycle request to run one transaction.
REQ-010 busy  output  1  high from the cycle after start is accepted until the cycle after done.
REQ-011 done  output  1  one-cycle pulse after the last result is captured.
REQ-012 tx_valid / tx_ready / tx_data[WIDTH]  output/input/output  operand stream towards the matvec engine.
REQ-013 rx_valid / rx_ready / rx_data[OUT_WIDTH]  input/output/input  result stream from the matvec engine; rx_data is signed.
REQ-014 rx_hold  input  1  when high, forces rx_ready low (back-pressure test hook).
REQ-015 rd_addr  input  2  result buffer read index.
REQ-016 rd_data  output  OUT_WIDTH  combinational read of result[rd_addr]; 0 for rd_addr = 3.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, RECV, DONE.
- IDLE->SEND on start.
- SEND->RECV on the 12th tx handshake.
- RECV->DONE on the 3rd rx handshake.
- DONE->IDLE unconditionally after one cycle.
REQ-018 In IDLE, ld_valid with ld_addr < 12 SHALL write ld_data into operand[ld_addr] at the clock edge.
- Writes with ld_addr >= 12, and all writes outside IDLE, SHALL be ignored.
REQ-019 If ld_valid and start are high in the same IDLE cycle, the write SHALL commit and the transaction SHALL transmit the newly written value.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 A tx transfer SHALL occur on any edge where tx_valid and tx_ready are both high.
REQ-022 tx_valid SHALL be registered and rise in the first SEND cycle, with tx_data = operand[0].
REQ-023 tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-024 After each transfer, tx_data SHALL advance to the next index in the following cycle, with no bubble while tx_ready stays high.
- Order: W[0][0], W[0][1] .. W[2][2], x[0], x[1], x[2].
REQ-025 tx_valid SHALL drop in the cycle after the 12th transfer and SHALL stay low outside SEND.
REQ-026 rx_ready SHALL equal (state==RECV) && !rx_hold, combinationally.
REQ-027 rx_valid while rx_ready is low SHALL NOT be captured.
REQ-028 Each rx handshake SHALL store rx_data into result[k], where k counts 0,1,2.
- The rx index SHALL clear on entry to SEND.
REQ-029 tx_ready high in RECV and rx_valid high in SEND SHALL have no effect; no overlap between the two phases.
REQ-030 A 4-bit tx index and a 2-bit rx index SHALL be the only counters; neither SHALL wrap within a transaction.
REQ-031 done SHALL be high exactly in the DONE cycle.
- result[] SHALL hold its values until overwritten by the next transaction.

Reset
REQ-032 On reset, the following SHALL take effect at the next edge regardless of the current state, including mid-SEND and mid-RECV:
- state = IDLE
- tx_valid = 0, busy = 0, done = 0
- both counters = 0
- result[0..2] = 0
REQ-033 Operand buffer contents SHALL NOT be affected by reset.
REQ-034 Following reset, no partial transaction SHALL resume; a new start SHALL be required.

Structure
REQ-035 A shared package SHALL define:
- the state enum;
- N, N_OPS = N*N+N, WIDTH, OUT_WIDTH;
- the constant X_BASE = N*N.
REQ-036 The operand buffer SHALL be one sub-module, operand_regfile: a 12 x WIDTH register file with one write port and one read port.
- The results SHALL be flat registers in the top module.

Verification
REQ-037 Load W = 1..9, x = (1,2,3); start with tx_ready and rx tied high; a matvec3 engine attached -> 12 tx words in order with no gaps; results 14, 32, 50; one done pulse.
REQ-038 Same load; tx_ready toggles 1,0,1,0… -> exactly 12 transfers, tx_data unchanged across every stall cycle.
REQ-039 rx_hold high for 5 cycles while rx_valid = 1 with rx_data = -7 -> no capture during the hold; captured into result[0] on the first cycle after rx_hold falls.
REQ-040 Reset asserted after the 6th tx transfer -> next cycle: tx_valid = 0, busy = 0, results = 0; a re-start resends from W[0][0] with the prior operands intact.
REQ-041 start while busy, ld_valid in SEND with ld_addr = 0 and ld_data = 99, and ld_addr = 13 in IDLE -> all ignored; transmitted W[0][0] and operand contents unchanged.
REQ-042 ld_valid (ld_addr = 0, ld_data = -5) and start in the same IDLE cycle -> first tx_data = -5.

Source files
------------

// File: rtl/matvec3_driver_pkg.sv
// ============================================================================
//  Module   : matvec3_driver_pkg
//  Purpose  : Shared sizing constants and FSM state type for matvec3_driver.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package matvec3_driver_pkg;

   localparam int N         = 3;
   localparam int N_OPS     = N * N + N;
   localparam int WIDTH     = 14;
   localparam int OUT_WIDTH = 28;
   localparam int X_BASE    = N * N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/matvec3_driver_operand_regfile.sv
// ============================================================================
//  Module   : operand_regfile
//  Purpose  : Operand buffer, one write port and one combinational read port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_regfile #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   // Contents deliberately survive reset so a restart reuses loaded operands.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (waddr <= c_LAST)) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = (raddr <= c_LAST) ? r_mem[raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/matvec3_driver.sv
// ============================================================================
//  Module   : matvec3_driver
//  Purpose  : Streams W and x to a matvec engine and collects the N results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matvec3_driver #(
   parameter int WIDTH     = matvec3_driver_pkg::WIDTH,
   parameter int OUT_WIDTH = matvec3_driver_pkg::OUT_WIDTH,
   parameter int N         = matvec3_driver_pkg::N
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_valid,
   input  logic [3:0]           ld_addr,
   input  logic [WIDTH-1:0]     ld_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [WIDTH-1:0]     tx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic [OUT_WIDTH-1:0] rx_data,
   input  logic                 rx_hold,
   input  logic [1:0]           rd_addr,
   output logic [OUT_WIDTH-1:0] rd_data
);

   import matvec3_driver_pkg::*;

   localparam int         c_N_OPS   = N * N + N;
   localparam logic [3:0] c_TX_LAST = 4'(c_N_OPS - 1);
   localparam logic [1:0] c_RX_LAST = 2'(N - 1);

   state_t               r_state;
   logic [3:0]           r_tx_idx;
   logic [1:0]           r_rx_idx;
   logic                 r_tx_valid;
   logic                 r_busy;
   logic                 r_done;
   logic [OUT_WIDTH-1:0] r_result [N];

   logic w_ld_we;
   logic w_tx_fire;
   logic w_rx_fire;

   assign w_ld_we   = (r_state == IDLE) && ld_valid && (ld_addr <= c_TX_LAST);
   assign w_tx_fire = (r_state == SEND) && r_tx_valid && tx_ready;
   assign rx_ready  = (r_state == RECV) && !rx_hold;
   assign w_rx_fire = rx_ready && rx_valid;

   // The read port follows the tx index, so tx_data holds while stalled.
   operand_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (c_N_OPS),
      .AW    (4)
   ) u_operands (
      .clk   (clk),
      .we    (w_ld_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (r_tx_idx),
      .rdata (tx_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tx_idx   <= '0;
         r_rx_idx   <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_result[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= SEND;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
                  r_tx_idx   <= '0;
                  r_rx_idx   <= '0;
               end
            end
            SEND: begin
               if (w_tx_fire) begin
                  if (r_tx_idx == c_TX_LAST) begin
                     r_tx_valid <= 1'b0;
                     r_state    <= RECV;
                  end else begin
                     r_tx_idx <= r_tx_idx + 4'd1;
                  end
               end
            end
            RECV: begin
               if (w_rx_fire) begin
                  r_result[r_rx_idx] <= rx_data;
                  if (r_rx_idx == c_RX_LAST) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_rx_idx <= r_rx_idx + 2'd1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx_valid = r_tx_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign rd_data  = (rd_addr <= c_RX_LAST) ? r_result[rd_addr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_matvec3_driver.sv
// ============================================================================
//  Module   : tb_matvec3_driver
//  Purpose  : Self-checking bench with a transaction-level model and engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matvec3_driver;

   localparam int WIDTH     = 14;
   localparam int OUT_WIDTH = 28;
   localparam int NOPS      = 12;

   logic                        clk;
   logic                        reset;
   logic                        ld_valid;
   logic [3:0]                  ld_addr;
   logic signed [WIDTH-1:0]     ld_data;
   logic                        start;
   logic                        busy;
   logic                        done;
   logic                        tx_valid;
   logic                        tx_ready;
   logic [WIDTH-1:0]            tx_data;
   logic                        rx_valid;
   logic                        rx_ready;
   logic [OUT_WIDTH-1:0]        rx_data;
   logic                        rx_hold;
   logic [1:0]                  rd_addr;
   logic [OUT_WIDTH-1:0]        rd_data;

   // rx and rd_addr sources are selected between the engine and directed code
   logic                        eng_auto, eng_rand, eng_rx_valid, man_valid;
   logic signed [OUT_WIDTH-1:0] eng_rx_data, man_data;
   logic                        rd_rand;
   logic [1:0]                  rd_fix, rd_rnd;

   assign rx_valid = eng_auto ? eng_rx_valid : man_valid;
   assign rx_data  = eng_auto ? eng_rx_data  : man_data;
   assign rd_addr  = rd_rand  ? rd_rnd       : rd_fix;

   matvec3_driver #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .N(3)) dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .start(start), .busy(busy), .done(done),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_hold(rx_hold), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic signed [WIDTH-1:0]     m_ops [NOPS];
   logic signed [OUT_WIDTH-1:0] m_res [3];
   bit m_active, m_done;
   int m_sent, m_got;

   initial begin
      foreach (m_ops[i]) m_ops[i] = '0;
      foreach (m_res[i]) m_res[i] = '0;
      m_active = 0; m_done = 0; m_sent = 0; m_got = 0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_active = 0; m_done = 0; m_sent = 0; m_got = 0;
            foreach (m_res[i]) m_res[i] = '0;
         end else if (m_done) begin
            m_done = 0; m_active = 0;
         end else if (!m_active) begin
            if (ld_valid && ld_addr < 4'd12) m_ops[ld_addr] = ld_data;
            if (start) begin
               m_active = 1; m_sent = 0; m_got = 0;
            end
         end else if (m_sent < NOPS) begin
            if (tx_ready) m_sent++;
         end else if (rx_valid && !rx_hold && m_got < 3) begin
            m_res[m_got] = rx_data;
            m_got++;
            if (m_got == 3) m_done = 1;
         end
      end
   end

   initial begin
      bit exp_v;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_v = m_active && !m_done && (m_sent < NOPS);
         check("busy", busy, m_active);
         check("done", done, m_done);
         check("tx_valid", tx_valid, exp_v);
         if (exp_v) check("tx_data", $signed(tx_data), m_ops[m_sent]);
         check("rx_ready", rx_ready,
               m_active && !m_done && (m_sent == NOPS) && (m_got < 3) && !rx_hold);
         check("rd_data", $signed(rd_data), (rd_addr < 2'd3) ? m_res[rd_addr] : 0);
      end
   end

   // ---------------- matvec engine on the far side of the streams ----------------
   logic signed [WIDTH-1:0]     eng_buf [NOPS];
   logic signed [OUT_WIDTH-1:0] eng_q [$];
   logic signed [WIDTH-1:0]     tx_log [$];
   int                          tx_stamp [$];
   int                          eng_n, cyc;

   initial begin
      bit tx_hs, rx_hs, rst_s;
      longint acc;
      eng_n = 0; cyc = 0; eng_rx_valid = 0; eng_rx_data = '0; rd_rnd = '0;
      forever begin
         @(negedge clk);
         rst_s = reset;
         tx_hs = tx_valid && tx_ready;
         rx_hs = eng_auto && eng_rx_valid && rx_ready;
         @(posedge clk);
         cyc++;
         if (rst_s) begin
            eng_n = 0;
            eng_q.delete();
         end else begin
            if (tx_hs) begin
               eng_buf[eng_n] = tx_data;
               tx_log.push_back(tx_data);
               tx_stamp.push_back(cyc);
               eng_n++;
               if (eng_n == NOPS) begin
                  for (int r = 0; r < 3; r++) begin
                     acc = 0;
                     for (int c = 0; c < 3; c++)
                        acc += longint'(eng_buf[r*3+c]) *
                               longint'(eng_buf[matvec3_driver_pkg::X_BASE + c]);
                     eng_q.push_back(OUT_WIDTH'(acc));
                  end
                  eng_n = 0;
               end
            end
            if (rx_hs && eng_q.size() > 0) void'(eng_q.pop_front());
         end
         #1;
         eng_rx_valid = (eng_q.size() > 0) && (!eng_rand || $urandom_range(0, 2) != 0);
         eng_rx_data  = (eng_q.size() > 0) ? eng_q[0] : '0;
         rd_rnd       = 2'($urandom_range(0, 3));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_op(input int a, input int v);
      ld_valid = 1'b1;
      ld_addr  = 4'(a);
      ld_data  = WIDTH'(v);
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic load_std();
      for (int i = 0; i < 9; i++) write_op(i, i + 1);
      for (int i = 0; i < 3; i++) write_op(9 + i, i + 1);
   endtask

   task automatic check_rd(input int a, input longint exp);
      rd_rand = 1'b0;
      rd_fix  = 2'(a);
      #1;
      check($sformatf("rd_data[%0d]", a), $signed(rd_data), exp);
   endtask

   task automatic check_std_results();
      check_rd(0, 14);
      check_rd(1, 32);
      check_rd(2, 50);
      check_rd(3, 0);
   endtask

   // mode 0: ready tied high, 1: ready toggles 1,0,..., 2: fully random
   task automatic run_txn(input int mode, input bit inject, input bit same_ld,
                          input int same_val, output int dones);
      bit seen, finished;
      eng_q.delete(); tx_log.delete(); tx_stamp.delete();
      dones = 0; seen = 0; finished = 0;
      eng_rand = (mode == 2);
      start    = 1'b1;
      if (same_ld) begin
         ld_valid = 1'b1; ld_addr = 4'd0; ld_data = WIDTH'(same_val);
      end
      tick();
      start = 1'b0; ld_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         case (mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (c % 2 == 0);
            default: begin
               tx_ready = 1'($urandom_range(0, 1));
               rx_hold  = ($urandom_range(0, 3) == 0);
               ld_valid = ($urandom_range(0, 2) == 0);
               ld_addr  = 4'($urandom_range(0, 15));
               ld_data  = WIDTH'($urandom);
               start    = ($urandom_range(0, 3) == 0);
            end
         endcase
         if (inject && c == 2) begin
            start = 1'b1; ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 14'sd99;
         end else if (inject && c == 3) begin
            start = 1'b0; ld_valid = 1'b0;
         end
         tick();
         if (done) begin
            dones++;
            seen = 1;
         end else if (seen && !busy) begin
            finished = 1;
            break;
         end
      end
      tx_ready = 1'b0; rx_hold = 1'b0; ld_valid = 1'b0; start = 1'b0; eng_rand = 1'b0;
      check("txn_completed", finished, 1);
   endtask

   task automatic wait_sent(input int n);
      for (int c = 0; c < 200 && m_sent < n; c++) tick();
      check("wait_sent", m_sent, n);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int dn;
      reset = 1; ld_valid = 0; ld_addr = '0; ld_data = '0; start = 0;
      tx_ready = 0; rx_hold = 0; eng_auto = 1; eng_rand = 0;
      man_valid = 0; man_data = '0; rd_rand = 0; rd_fix = '0;
      repeat (3) tick();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_tx_valid", tx_valid, 0);
      check("reset_rx_ready", rx_ready, 0);
      check_rd(0, 0);
      reset = 0;
      tick();

      // Basic transaction, streams tied high
      load_std();
      run_txn(0, 0, 0, 0, dn);
      check("t1_done_pulses", dn, 1);
      check("t1_tx_count", tx_log.size(), 12);
      if (tx_log.size() == 12) begin
         for (int i = 0; i < 12; i++)
            check($sformatf("t1_tx_word%0d", i), tx_log[i], (i < 9) ? i + 1 : i - 8);
         check("t1_no_gaps", tx_stamp[11] - tx_stamp[0], 11);
      end
      check_std_results();

      // Toggling tx_ready
      rd_rand = 1;
      run_txn(1, 0, 0, 0, dn);
      check("t2_tx_count", tx_log.size(), 12);
      check_std_results();

      // rx back-pressure with a manually driven rx stream
      eng_auto = 0; man_valid = 1; man_data = -28'sd7; rx_hold = 1; tx_ready = 1;
      eng_q.delete();
      start = 1; tick(); start = 0;
      wait_sent(12);
      repeat (5) tick();
      check("t3_busy_in_hold", busy, 1);
      check_rd(0, 14);
      rx_hold = 0;
      tick();
      check_rd(0, -7);
      man_data = 28'sd100; tick();
      man_data = 28'sd200; tick();
      check("t3_done", done, 1);
      man_valid = 0; tx_ready = 0;
      tick();
      check_rd(1, 100);
      check_rd(2, 200);
      eng_auto = 1; eng_q.delete();

      // Reset in the middle of SEND
      tx_log.delete();
      tx_ready = 1; start = 1; tick(); start = 0;
      wait_sent(6);
      reset = 1; tick(); reset = 0;
      check("t4_tx_valid", tx_valid, 0);
      check("t4_busy", busy, 0);
      check_rd(0, 0); check_rd(1, 0); check_rd(2, 0);
      repeat (3) tick();
      check("t4_no_resume", tx_valid, 0);
      run_txn(0, 0, 0, 0, dn);
      check("t4_restart_count", tx_log.size(), 12);
      if (tx_log.size() > 0) check("t4_restart_w00", tx_log[0], 1);
      check_std_results();

      // Ignored start/load while busy, ignored out-of-range load
      run_txn(0, 1, 0, 0, dn);
      check("t5_done_pulses", dn, 1);
      write_op(13, 77);
      run_txn(0, 0, 0, 0, dn);
      if (tx_log.size() > 0) check("t5_w00_kept", tx_log[0], 1);
      check_std_results();

      // Write and start in the same cycle
      run_txn(0, 0, 1, -5, dn);
      if (tx_log.size() > 0) check("t6_first_tx", tx_log[0], -5);
      check_rd(0, 8);
      check_rd(1, 32);

      // Randomized transactions
      rd_rand = 1;
      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < 16; k++) write_op($urandom_range(0, 15), $urandom);
         run_txn(2, 0, 0, 0, dn);
         check("rand_done_pulses", dn, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
